// File: rtl/div_pkg.sv
// Shared types and constants for the sequential 8-bit signed/unsigned divider.
`timescale 1ns/1ps
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_t;

  localparam int WIDTH = 8;
  localparam int ITERS = 8;
  localparam int CNT_W = 3;

  localparam logic [CNT_W-1:0] LAST_CNT  = 3'd7;
  localparam logic [WIDTH-1:0] DIVZERO_Q = 8'hFF;
  localparam logic [WIDTH-1:0] OVF_Q     = 8'h80;

  // Magnitude of an operand: absolute value in signed mode (0x80 -> 128),
  // pass-through in unsigned mode.
  function automatic logic [WIDTH-1:0] mag8(input logic [WIDTH-1:0] v, input logic sm);
    if (sm && v[WIDTH-1]) begin
      return ~v + 8'd1;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration of the divider.
`timescale 1ns/1ps
module div_step
  import div_pkg::*;
(
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH:0]   rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH+1:0] shifted_s;
  logic [WIDTH+1:0] trial_s;

  // Shift {remainder, quotient} left, trial-subtract, restore on a negative result.
  always_comb begin
    shifted_s = {rem_in, quo_in[WIDTH-1]};
    trial_s   = shifted_s - {2'b00, dvs};
    if (trial_s[WIDTH+1] == 1'b0) begin
      rem_out = trial_s[WIDTH:0];
      quo_out = {quo_in[WIDTH-2:0], 1'b1};
    end else begin
      rem_out = shifted_s[WIDTH:0];
      quo_out = {quo_in[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/signed_divider8.sv
// Sequential 8-bit divider: IDLE -> CALC (8 iterations) -> FIX, with
// sign fix-up and divide-by-zero / signed-overflow handling.
`timescale 1ns/1ps
module signed_divider8
  import div_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             SignedMode,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             DivZero,
  output logic             Overflow
);

  div_state_t       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH:0]   rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] dvs_mag_r;
  logic [WIDTH-1:0] dividend_r;
  logic [WIDTH-1:0] divisor_r;
  logic             signed_r;
  logic             qsign_r;
  logic             rsign_r;

  logic [WIDTH:0]   rem_next_s;
  logic [WIDTH-1:0] quo_next_s;
  logic [WIDTH-1:0] fix_q_s;
  logic [WIDTH-1:0] fix_r_s;
  logic             fix_dz_s;
  logic             fix_ovf_s;

  div_step u_step (
    .rem_in  (rem_r),
    .quo_in  (quo_r),
    .dvs     (dvs_mag_r),
    .rem_out (rem_next_s),
    .quo_out (quo_next_s)
  );

  // Final result selection: corner cases first, then sign fix-up of the magnitudes.
  always_comb begin
    fix_q_s   = quo_r;
    fix_r_s   = 8'(rem_r);
    fix_dz_s  = 1'b0;
    fix_ovf_s = 1'b0;
    if (divisor_r == 8'h00) begin
      fix_q_s  = DIVZERO_Q;
      fix_r_s  = dividend_r;
      fix_dz_s = 1'b1;
    end else if (signed_r && (dividend_r == 8'h80) && (divisor_r == 8'hFF)) begin
      fix_q_s   = OVF_Q;
      fix_r_s   = 8'h00;
      fix_ovf_s = 1'b1;
    end else begin
      fix_q_s = (signed_r && qsign_r) ? (~quo_r + 8'd1) : quo_r;
      fix_r_s = 8'((signed_r && rsign_r) ? (~rem_r + 9'd1) : rem_r);
    end
  end

  // Control FSM, iteration datapath and registered result outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r    <= IDLE;
      cnt_r      <= 3'd0;
      rem_r      <= 9'd0;
      quo_r      <= 8'd0;
      dvs_mag_r  <= 8'd0;
      dividend_r <= 8'd0;
      divisor_r  <= 8'd0;
      signed_r   <= 1'b0;
      qsign_r    <= 1'b0;
      rsign_r    <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Quotient   <= 8'd0;
      Remainder  <= 8'd0;
      DivZero    <= 1'b0;
      Overflow   <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (Start) begin
            dividend_r <= Dividend;
            divisor_r  <= Divisor;
            signed_r   <= SignedMode;
            dvs_mag_r  <= mag8(Divisor, SignedMode);
            quo_r      <= mag8(Dividend, SignedMode);
            qsign_r    <= Dividend[WIDTH-1] ^ Divisor[WIDTH-1];
            rsign_r    <= Dividend[WIDTH-1];
            rem_r      <= 9'd0;
            cnt_r      <= 3'd0;
            Busy       <= 1'b1;
            state_r    <= CALC;
          end else begin
            state_r <= IDLE;
          end
        end
        CALC: begin
          rem_r <= rem_next_s;
          quo_r <= quo_next_s;
          cnt_r <= cnt_r + 3'd1;
          if (cnt_r == LAST_CNT) begin
            state_r <= FIX;
          end else begin
            state_r <= CALC;
          end
        end
        FIX: begin
          Quotient  <= fix_q_s;
          Remainder <= fix_r_s;
          DivZero   <= fix_dz_s;
          Overflow  <= fix_ovf_s;
          Done      <= 1'b1;
          Busy      <= 1'b0;
          state_r   <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          Busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/signed_divider8.md
# signed_divider8

Sequential 8-bit divider, the inverse operation of the lab-5 shift-add multiplier datapath. It performs restoring shift-subtract division over a fixed 8-iteration schedule, using one 9-bit trial subtract per cycle. It supports unsigned and two's-complement operands, and hands results to the register/hex-display path with a one-cycle done pulse.

## Interface
Parameters:
- none; widths are fixed by the package constants (`WIDTH` = 8, `ITERS` = 8).

Ports:
- `Clk`  in  1  system clock, all state on rising edge
- `Reset`  in  1  synchronous, active-high; dominates all other inputs
- `Start`  in  1  request; sampled only in IDLE
- `SignedMode`  in  1  1 = two's complement, 0 = unsigned; latched with operands
- `Dividend`  in  8  numerator; latched on Start acceptance
- `Divisor`  in  8  denominator; latched on Start acceptance
- `Busy`  out  1  high from acceptance until result write
- `Done`  out  1  one-cycle pulse coincident with new results
- `Quotient`  out  8  result quotient
- `Remainder`  out  8  result remainder
- `DivZero`  out  1  last op had `Divisor` = 0
- `Overflow`  out  1  last op was signed −128 / −1

## Operation
- States: IDLE → CALC → FIX → IDLE.
- IDLE:
  - On `Start` = 1, latch the operands and mode.
  - Form magnitudes. Signed mode takes the absolute value as 8-bit unsigned, so 0x80 → 128. Unsigned mode passes operands through.
  - Record the quotient sign (dividend sign XOR divisor sign) and the remainder sign (dividend sign).
  - Clear the 9-bit partial remainder, load the dividend magnitude into the quotient shift register, clear the counter, and go to CALC.
- CALC, one iteration per cycle for 8 cycles (counter 0..7):
  - Shift {partial remainder, quotient register} left by 1.
  - Trial = shifted remainder − {0, divisor magnitude}, computed in 10 bits.
  - If the trial is non-negative, the remainder becomes the trial and the quotient LSB = 1. Otherwise the remainder is restored and the LSB = 0.
  - After counter = 7, go to FIX.
- FIX, one cycle, writes all result outputs and sets `Done`:
  - Signed mode: negate the quotient magnitude if the quotient sign is 1, and negate the remainder if the remainder sign is 1. Truncation is toward zero, and the remainder takes the dividend's sign.
  - Divisor = 0 (either mode): `Quotient` = 0xFF, `Remainder` = latched dividend, `DivZero` = 1. The iteration schedule still runs in full.
  - Signed 0x80 / 0xFF: `Quotient` = 0x80, `Remainder` = 0x00, `Overflow` = 1.
  - Otherwise `DivZero` = `Overflow` = 0.
- `Start` while not in IDLE is ignored. Operand changes after acceptance are ignored.
- Result outputs hold their value until the next FIX write.

## Timing
- Reset values: state IDLE. `Busy`, `Done`, `Quotient`, `Remainder`, `DivZero`, `Overflow` all 0.
- `Start` sampled high at edge N:
  - `Busy` = 1 after edge N.
  - Iterations occur at edges N+1 … N+8.
  - FIX occurs at edge N+9: results valid, `Done` = 1, `Busy` = 0.
  - `Done` clears at edge N+10.
- Fixed latency: 9 cycles from acceptance to results, independent of operands and corner cases.
- Earliest next acceptance is edge N+10 (state is IDLE after N+9). Throughput is one op per 10 cycles with `Start` held high.
- `Reset` at any edge, including mid-CALC or in FIX: next state IDLE, all outputs 0, no `Done` pulse for the aborted op.
- `Reset` and `Start` high at the same edge: `Reset` wins, nothing is accepted.

## Structure
- Package `div_pkg`:
  - state enum `div_state_t` {IDLE, CALC, FIX}
  - `WIDTH` = 8, `ITERS` = 8, counter width 3
  - constants `DIVZERO_Q` = 8'hFF, `OVF_Q` = 8'h80
- Sub-module `div_step` (combinational): one restoring iteration.
  - Inputs: 9-bit partial remainder, quotient register, divisor magnitude.
  - Outputs: next remainder, next quotient register.
- Top level owns the FSM, counter, operand latches, sign fix-up and corner-case muxing.

## Test plan
- Unsigned 200 / 7 (0xC8 / 0x07) → `Quotient` = 0x1C, `Remainder` = 0x04, `Done` pulse exactly at edge N+9, flags 0.
- Signed −7 / 2 (0xF9 / 0x02) → `Quotient` = 0xFD, `Remainder` = 0xFF. Signed −128 / 3 (0x80 / 0x03) → `Quotient` = 0xD6, `Remainder` = 0xFE.
- Signed 0x80 / 0xFF → `Quotient` = 0x80, `Remainder` = 0x00, `Overflow` = 1. Unsigned 0x80 / 0xFF → `Quotient` = 0x00, `Remainder` = 0x80, `Overflow` = 0.
- Divisor 0, signed, dividend 0x85 → `Quotient` = 0xFF, `Remainder` = 0x85, `DivZero` = 1, latency still 9.
- `Start` held high continuously with operands changing every cycle → ops accepted at N, N+10, N+20. Each result matches only the operands present at its acceptance edge.
- `Reset` at edge N+4 of an op → `Busy` = 0 and all outputs 0 at N+4, no `Done` pulse. A fresh `Start` at N+6 completes normally at N+15.
